// File: rtl/fb_pkg.sv
// Shared types and screen geometry for the frame buffer pair and its
// swap controller.
package fb_pkg;

    typedef enum logic [1:0] {
        START  = 2'd0,
        RENDER = 2'd1,
        DONE   = 2'd2,
        SWAP   = 2'd3
    } fb_state_t;

    localparam int SCREEN_W_FULL = 1280;
    localparam int SCREEN_H_FULL = 720;
    localparam int SCREEN_W      = 320;
    localparam int SCREEN_H      = 180;
    localparam int PIXEL_WIDTH   = 16;

endpackage

// File: rtl/frame_tick_gen.sv
// Swap-point detector: pulses once per video frame at pixel 0 of line SWAP_VCOUNT.
// Ports: hcount_in[10:0], vcount_in[9:0] from video_sig_gen; frame_tick_out.
module frame_tick_gen #(
    parameter int SWAP_VCOUNT = 720
) (
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    output logic        frame_tick_out
);

    localparam logic [9:0] SWAP_LINE = 10'(SWAP_VCOUNT);

    assign frame_tick_out = (hcount_in == 11'd0) && (vcount_in == SWAP_LINE);

endmodule

// File: rtl/fb_swap_controller.sv
// Double-buffer sequencer: gates raycaster writes into the back buffer and
// swaps buffers in vertical blanking once a render is complete.
// Ports: pixel_clk_in, rst_in (sync, active-high), hcount_in, vcount_in,
// ray_valid_in, ray_last_pixel_in, ray_ready_out, fb_we_out,
// render_start_out, buf_sel_out, swap_out, repeat_count_out, state_out.
module fb_swap_controller
    import fb_pkg::*;
#(
    parameter int FULL_SCREEN_WIDTH  = SCREEN_W_FULL,
    parameter int FULL_SCREEN_HEIGHT = SCREEN_H_FULL,
    parameter int SWAP_VCOUNT        = FULL_SCREEN_HEIGHT,
    parameter int REPEAT_W           = 8
) (
    input  logic                pixel_clk_in,
    input  logic                rst_in,
    input  logic [10:0]         hcount_in,
    input  logic [9:0]          vcount_in,
    input  logic                ray_valid_in,
    input  logic                ray_last_pixel_in,
    output logic                ray_ready_out,
    output logic                fb_we_out,
    output logic                render_start_out,
    output logic                buf_sel_out,
    output logic                swap_out,
    output logic [REPEAT_W-1:0] repeat_count_out,
    output logic [1:0]          state_out
);

    // The swap line must lie in blanking and fit the video counters.
    if ((SWAP_VCOUNT < FULL_SCREEN_HEIGHT) || (SWAP_VCOUNT > 1023) ||
        (FULL_SCREEN_WIDTH > 2048)) begin : g_bad_cfg
        $error("fb_swap_controller: SWAP_VCOUNT outside blanking");
    end

    fb_state_t             state;
    logic                  buf_sel;
    logic [REPEAT_W-1:0]   repeat_cnt;
    logic                  frame_tick;
    logic                  last_accepted;

    frame_tick_gen #(
        .SWAP_VCOUNT(SWAP_VCOUNT)
    ) u_tick (
        .hcount_in     (hcount_in),
        .vcount_in     (vcount_in),
        .frame_tick_out(frame_tick)
    );

    assign ray_ready_out = (state == RENDER);
    assign fb_we_out     = ray_valid_in & ray_ready_out;
    assign last_accepted = fb_we_out & ray_last_pixel_in;

    // State is already START while reset is held; the start pulse must only
    // appear once the raycaster is out of reset.
    assign render_start_out = ~rst_in & ((state == START) | (state == SWAP));
    assign swap_out         = (state == SWAP);
    assign buf_sel_out      = buf_sel;
    assign repeat_count_out = repeat_cnt;
    assign state_out        = state;

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            state      <= START;
            buf_sel    <= 1'b0;
            repeat_cnt <= '0;
        end else begin
            unique case (state)
                START: state <= RENDER;
                RENDER: begin
                    if (last_accepted && frame_tick) begin
                        // Last pixel lands in the old back buffer, then swap.
                        state   <= SWAP;
                        buf_sel <= ~buf_sel;
                    end else if (last_accepted) begin
                        state <= DONE;
                    end else if (frame_tick) begin
                        // Display shows the current front buffer again.
                        if (repeat_cnt != '1) begin
                            repeat_cnt <= repeat_cnt + REPEAT_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (frame_tick) begin
                        state   <= SWAP;
                        buf_sel <= ~buf_sel;
                    end
                end
                SWAP: state <= RENDER;
                default: state <= START;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_swap_controller.sv
// Self-checking bench for fb_swap_controller: directed vector table,
// repeat-counter saturation run and randomized run against a reference model.
module tb_fb_swap_controller;

    logic        pixel_clk_in = 1'b0;
    logic        rst_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        ray_valid_in;
    logic        ray_last_pixel_in;
    logic        ray_ready_out;
    logic        fb_we_out;
    logic        render_start_out;
    logic        buf_sel_out;
    logic        swap_out;
    logic [7:0]  repeat_count_out;
    logic [1:0]  state_out;

    int checks = 0;
    int errors = 0;

    // Reference model: phase numbers as defined for state_out.
    int   m_phase = 0;
    logic m_sel   = 1'b0;
    int   m_rep   = 0;

    always #5 pixel_clk_in = ~pixel_clk_in;

    fb_swap_controller dut (
        .pixel_clk_in     (pixel_clk_in),
        .rst_in           (rst_in),
        .hcount_in        (hcount_in),
        .vcount_in        (vcount_in),
        .ray_valid_in     (ray_valid_in),
        .ray_last_pixel_in(ray_last_pixel_in),
        .ray_ready_out    (ray_ready_out),
        .fb_we_out        (fb_we_out),
        .render_start_out (render_start_out),
        .buf_sel_out      (buf_sel_out),
        .swap_out         (swap_out),
        .repeat_count_out (repeat_count_out),
        .state_out        (state_out)
    );

    typedef struct {
        logic       rst, v, l, t;
        logic [1:0] st;
        logic       rdy, we, start, swp, sel;
        logic [7:0] rep;
    } vec_t;

    vec_t tbl[21];

    function automatic logic [14:0] dut_vec();
        return {state_out, ray_ready_out, fb_we_out, render_start_out,
                swap_out, buf_sel_out, repeat_count_out};
    endfunction

    task automatic cmp(input string nm, input logic [14:0] act,
                       input logic [14:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got st=%0d rdy/we/start/swap/sel=%b rep=%0d, expected st=%0d rdy/we/start/swap/sel=%b rep=%0d",
                     nm, act[14:13], act[12:8], act[7:0],
                     exp[14:13], exp[12:8], exp[7:0]);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic l,
                         input logic t);
        logic [10:0] h;
        logic [9:0]  vc;
        rst_in            = r;
        ray_valid_in      = v;
        ray_last_pixel_in = l;
        if (t) begin
            h  = 11'd0;
            vc = 10'd720;
        end else begin
            case ($urandom_range(3, 0))
                0: begin h = 11'd0; vc = 10'd719; end
                1: begin h = 11'd1; vc = 10'd720; end
                2: begin h = 11'd0; vc = 10'd721; end
                default: begin
                    h  = 11'($urandom_range(1279, 0));
                    vc = 10'($urandom_range(749, 0));
                    if (h == 11'd0 && vc == 10'd720) h = 11'd5;
                end
            endcase
        end
        hcount_in = h;
        vcount_in = vc;
    endtask

    function automatic logic [14:0] model_vec();
        logic rdy;
        rdy = (m_phase == 1);
        return {2'(m_phase), rdy, ray_valid_in & rdy,
                ~rst_in & (m_phase == 0 || m_phase == 3),
                logic'(m_phase == 3), m_sel, 8'(m_rep)};
    endfunction

    task automatic clk_edge();
        logic tick;
        logic acc;
        @(posedge pixel_clk_in);
        tick = (hcount_in == 11'd0) && (vcount_in == 10'd720);
        acc  = ray_valid_in && ray_last_pixel_in && (m_phase == 1);
        if (rst_in) begin
            m_phase = 0;
            m_sel   = 1'b0;
            m_rep   = 0;
        end else if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1) begin
            if (acc && tick) begin
                m_phase = 3;
                m_sel   = ~m_sel;
            end else if (acc) begin
                m_phase = 2;
            end else if (tick) begin
                m_rep = (m_rep < 255) ? m_rep + 1 : 255;
            end
        end else if (m_phase == 2) begin
            if (tick) begin
                m_phase = 3;
                m_sel   = ~m_sel;
            end
        end else begin
            m_phase = 1;
        end
        #1;
    endtask

    initial begin
        tbl[0]  = '{1,1,0,0, 0,0,0,0,0,0,0};
        tbl[1]  = '{0,0,0,0, 0,0,0,1,0,0,0};
        tbl[2]  = '{0,1,0,0, 1,1,1,0,0,0,0};
        tbl[3]  = '{0,1,1,0, 1,1,1,0,0,0,0};
        tbl[4]  = '{0,1,1,0, 2,0,0,0,0,0,0};
        tbl[5]  = '{0,0,0,0, 2,0,0,0,0,0,0};
        tbl[6]  = '{0,0,0,1, 2,0,0,0,0,0,0};
        tbl[7]  = '{0,0,0,0, 3,0,0,1,1,1,0};
        tbl[8]  = '{0,0,0,1, 1,1,0,0,0,1,0};
        tbl[9]  = '{0,0,0,1, 1,1,0,0,0,1,1};
        tbl[10] = '{0,0,0,1, 1,1,0,0,0,1,2};
        tbl[11] = '{0,1,1,0, 1,1,1,0,0,1,3};
        tbl[12] = '{0,0,0,1, 2,0,0,0,0,1,3};
        tbl[13] = '{0,0,0,0, 3,0,0,1,1,0,3};
        tbl[14] = '{0,1,1,1, 1,1,1,0,0,0,3};
        tbl[15] = '{0,0,0,0, 3,0,0,1,1,1,3};
        tbl[16] = '{0,1,1,0, 1,1,1,0,0,1,3};
        tbl[17] = '{1,0,0,0, 2,0,0,0,0,1,3};
        tbl[18] = '{1,0,0,0, 0,0,0,0,0,0,0};
        tbl[19] = '{0,0,0,0, 0,0,0,1,0,0,0};
        tbl[20] = '{0,0,0,0, 1,1,0,0,0,0,0};

        drive(1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        clk_edge();

        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].rst, tbl[i].v, tbl[i].l, tbl[i].t);
            #1;
            cmp($sformatf("vec%0d", i), dut_vec(),
                {tbl[i].st, tbl[i].rdy, tbl[i].we, tbl[i].start,
                 tbl[i].swp, tbl[i].sel, tbl[i].rep});
            clk_edge();
        end

        // Long overrun: 300 frame ticks with no completed render.
        for (int i = 0; i < 300; i++) begin
            drive(1'b0, 1'($urandom_range(1, 0)), 1'b0, 1'b1);
            #1;
            cmp($sformatf("sat%0d", i), dut_vec(), model_vec());
            clk_edge();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        cmp("sat_final", dut_vec(), {2'd1, 5'b10000, 8'd255});
        clk_edge();

        // Finish that render and swap, then random traffic.
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        #1;
        cmp("sat_last", dut_vec(), model_vec());
        clk_edge();
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        cmp("sat_tick", dut_vec(), model_vec());
        clk_edge();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        cmp("sat_swap", dut_vec(), {2'd3, 5'b00111, 8'd255});
        clk_edge();

        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(199, 0) == 0),
                  1'($urandom_range(1, 0)),
                  1'($urandom_range(7, 0) == 0),
                  1'($urandom_range(9, 0) == 0));
            #1;
            cmp($sformatf("rnd%0d", i), dut_vec(), model_vec());
            clk_edge();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
